// File: rtl/rgb_fade_pwm.sv
// rgb_fade_pwm -- single-colour fading PWM source for the RGB LED driver.
//
// A brightness target arrives over a valid/ready handshake. The current
// level slews one LSB toward it every P_STEP_PERIODS PWM periods, and the
// PWM duty is shadowed so it only changes on a period boundary.
//
// Optional feature: define RGB_FADE_PWM_GAMMA_EN to map the level through a
// square-law curve, duty = (L*L + 255) >> 8, before it reaches the PWM
// comparator. Undefined (default): duty = level, no multiplier.
//
// Parameters:
//   P_PRESCALE      system clocks per PWM counter tick (>=1)
//   P_STEP_PERIODS  PWM periods per one-LSB level step (>=1)
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_target[7:0]  requested brightness level
//   i_valid        i_target is valid
//   o_ready        block can accept a new target (IDLE)
//   o_level[7:0]   current slewed brightness level
//   o_period_end   one-cycle pulse following the last tick of each period
//   o_led          registered PWM output
module rgb_fade_pwm #(
   parameter int P_PRESCALE     = 94,
   parameter int P_STEP_PERIODS = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_target,
   input  logic       i_valid,
   output logic       o_ready,
   output logic [7:0] o_level,
   output logic       o_period_end,
   output logic       o_led
);

   localparam int PS_W = (P_PRESCALE > 1) ? $clog2(P_PRESCALE) : 1;
   localparam int ST_W = (P_STEP_PERIODS > 1) ? $clog2(P_STEP_PERIODS) : 1;
   localparam logic [PS_W-1:0] PS_MAX = PS_W'(P_PRESCALE - 1);
   localparam logic [ST_W-1:0] ST_MAX = ST_W'(P_STEP_PERIODS - 1);

   typedef enum logic {IDLE, FADE} state_e;

   state_e          state_q, state_d;
   logic [PS_W-1:0] presc_q, presc_d;
   logic [7:0]      pwm_cnt_q, pwm_cnt_d;
   logic [ST_W-1:0] step_q, step_d;
   logic [7:0]      level_q, level_d;
   logic [7:0]      target_q, target_d;
   logic [7:0]      duty_q, duty_d;
   logic            led_q, led_d;
   logic            pe_q;
   logic            tick;
   logic            period_end;
   logic [7:0]      duty_f;

   // Timebase: prescaler -> tick -> 8-bit PWM counter.
   always_comb begin
      tick       = (presc_q == PS_MAX);
      presc_d    = tick ? '0 : presc_q + PS_W'(1);
      pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      period_end = tick && (pwm_cnt_q == 8'hFF);
   end

   // Level-to-duty mapping.
`ifdef RGB_FADE_PWM_GAMMA_EN
   logic [15:0] sq;
   always_comb begin
      sq     = 16'(level_q) * 16'(level_q);
      // +255 rounds up so any non-zero level still lights the LED.
      duty_f = 8'((sq + 16'd255) >> 8);
   end
`else
   always_comb duty_f = level_q;
`endif

   // Duty only reloads at the period boundary, so a period is never split
   // between two duty values. It takes the pre-step level on purpose.
   always_comb begin
      duty_d = period_end ? duty_f : duty_q;
      led_d  = (pwm_cnt_q < duty_q);
   end

   // Handshake and slewing FSM.
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      step_d   = step_q;
      level_d  = level_q;
      case (state_q)
         IDLE: begin
            // Acceptance takes priority over any coincident period_end.
            if (i_valid) begin
               target_d = i_target;
               step_d   = '0;
               if (i_target != level_q) state_d = FADE;
            end
         end
         FADE: begin
            if (period_end) begin
               if (step_q == ST_MAX) begin
                  step_d  = '0;
                  // level_q != target_q holds throughout FADE, so this
                  // never overshoots or wraps.
                  level_d = (level_q < target_q) ? level_q + 8'd1 : level_q - 8'd1;
                  if (level_d == target_q) state_d = IDLE;
               end else begin
                  step_d = step_q + ST_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         pwm_cnt_q <= '0;
         step_q    <= '0;
         level_q   <= '0;
         target_q  <= '0;
         duty_q    <= '0;
         led_q     <= 1'b0;
         pe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         pwm_cnt_q <= pwm_cnt_d;
         step_q    <= step_d;
         level_q   <= level_d;
         target_q  <= target_d;
         duty_q    <= duty_d;
         led_q     <= led_d;
         pe_q      <= period_end;
      end
   end

   assign o_ready      = (state_q == IDLE);
   assign o_level      = level_q;
   assign o_period_end = pe_q;
   assign o_led        = led_q;

endmodule
